digit_overlay: RTL and testbench

Pixel-pipeline overlay that renders an N-digit BCD number as 7-segment-style glyphs into the display stream, between the pixel-coordinate generator and the colour output stage. The displayed value is shadowed and committed only at frame start, so updates are tear-free. The block supports integer glyph scaling, leading-zero blanking, a minus sign and frame-counted blinking. Pixels outside the overlay box pass through unchanged with fixed latency.

---
 rtl/digit_pkg.sv | 43 ++++
 rtl/glyph_seg_rom.sv | 34 +++
 rtl/digit_overlay.sv | 164 ++++++++++++++++
 tb/tb_digit_overlay.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared definitions for the 7-segment BCD overlay.
// Holds segment ids, per-code segment maps, stroke geometry and default colours.
package digit_pkg;

    typedef enum logic [2:0] {
        SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G
    } seg_e;

    localparam int NUM_SEGS = 7;

    // Bit i lights segment seg_e'(i). Entry [code] covers codes 0..15.
    localparam logic [15:0][NUM_SEGS-1:0] SEG_MAP = {
        7'h40,                              // 15: minus
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00,  // 14..10: blank
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,  // 9..5
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F   // 4..0
    };

    localparam logic [3:0] BLANK_CODE = 4'hA;
    localparam logic [3:0] MINUS_CODE = 4'hF;

    // Stroke geometry in glyph-cell coordinates (8 x 16 cell).
    localparam int STROKE_L = 1;
    localparam int STROKE_R = 6;
    localparam int A_ROW_T  = 1;
    localparam int A_ROW_B  = 2;
    localparam int UPPER_T  = 1;
    localparam int UPPER_B  = 7;
    localparam int G_ROW_T  = 7;
    localparam int G_ROW_B  = 8;
    localparam int LOWER_T  = 8;
    localparam int LOWER_B  = 14;
    localparam int D_ROW_T  = 13;
    localparam int D_ROW_B  = 14;

    localparam logic [5:0] DEF_FG_COLOR = 6'b000000;
    localparam logic [5:0] DEF_BG_COLOR = 6'b111111;

    function automatic logic in_band(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/glyph_seg_rom.sv
// Combinational glyph lookup: which segment regions cover (gcol, grow), masked
// by the segment map of the digit code.
module glyph_seg_rom
    import digit_pkg::*;
#(
    parameter int COL_W = 3,
    parameter int ROW_W = 4
) (
    input  logic [3:0]       code_i,
    input  logic [COL_W-1:0] gcol_i,
    input  logic [ROW_W-1:0] grow_i,
    output logic             lit_o
);

    logic [NUM_SEGS-1:0] region;
    int                  col;
    int                  row;

    always_comb begin
        col    = int'(gcol_i);
        row    = int'(grow_i);
        region = '0;
        region[SEG_A] = in_band(col, STROKE_L, STROKE_R) && in_band(row, A_ROW_T, A_ROW_B);
        region[SEG_B] = (col == STROKE_R) && in_band(row, UPPER_T, UPPER_B);
        region[SEG_C] = (col == STROKE_R) && in_band(row, LOWER_T, LOWER_B);
        region[SEG_D] = in_band(col, STROKE_L, STROKE_R) && in_band(row, D_ROW_T, D_ROW_B);
        region[SEG_E] = (col == STROKE_L) && in_band(row, LOWER_T, LOWER_B);
        region[SEG_F] = (col == STROKE_L) && in_band(row, UPPER_T, UPPER_B);
        region[SEG_G] = in_band(col, STROKE_L, STROKE_R) && in_band(row, G_ROW_T, G_ROW_B);
    end

    assign lit_o = |(region & SEG_MAP[code_i]);

endmodule

// File: rtl/digit_overlay.sv
// Two-stage pixel overlay drawing a tear-free BCD readout as scaled 7-segment glyphs.
// Stage 1: box test, glyph coordinates, digit code select. Stage 2: glyph lookup, colour mux.
module digit_overlay
    import digit_pkg::*;
#(
    parameter int                 NUM_DIGITS   = 4,
    parameter int                 GLYPH_W      = 8,
    parameter int                 GLYPH_H      = 16,
    parameter int                 SCALE_LOG2   = 1,
    parameter int                 X0           = 16,
    parameter int                 Y0           = 16,
    parameter int                 COLOR_W      = 6,
    parameter logic [COLOR_W-1:0] FG_COLOR     = DEF_FG_COLOR,
    parameter logic [COLOR_W-1:0] BG_COLOR     = DEF_BG_COLOR,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    input  logic                    value_valid,
    input  logic                    frame_start,
    input  logic                    lzb_en,
    input  logic                    blink_en,
    input  logic                    px_valid,
    input  logic [9:0]              px_x,
    input  logic [9:0]              px_y,
    input  logic [COLOR_W-1:0]      pix_in,
    output logic [COLOR_W-1:0]      pix_out,
    output logic                    pix_out_valid
);

    localparam int GW_LOG2 = $clog2(GLYPH_W);
    localparam int GH_LOG2 = $clog2(GLYPH_H);
    localparam int BOX_W   = (NUM_DIGITS * GLYPH_W) << SCALE_LOG2;
    localparam int BOX_H   = GLYPH_H << SCALE_LOG2;
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // ---------------- value shadowing ----------------
    logic [NUM_DIGITS-1:0][3:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0][3:0] shad_q, shad_d;

    // A write coinciding with frame_start is committed at that same frame_start.
    always_comb begin
        pend_d = pend_q;
        shad_d = shad_q;
        if (value_valid) pend_d = value_bcd;
        if (frame_start) shad_d = pend_d;
    end

    // ---------------- blink phase ----------------
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic            phase_on_q, phase_on_d;

    always_comb begin
        bcnt_d     = bcnt_q;
        phase_on_d = phase_on_q;
        if (!blink_en) begin
            bcnt_d     = '0;
            phase_on_d = 1'b1;
        end else if (frame_start) begin
            if (bcnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                bcnt_d     = '0;
                phase_on_d = !phase_on_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= {NUM_DIGITS{BLANK_CODE}};
            shad_q     <= {NUM_DIGITS{BLANK_CODE}};
            bcnt_q     <= '0;
            phase_on_q <= 1'b1;
        end else begin
            pend_q     <= pend_d;
            shad_q     <= shad_d;
            bcnt_q     <= bcnt_d;
            phase_on_q <= phase_on_d;
        end
    end

    // ---------------- stage 1: geometry and digit select ----------------
    logic [9:0]         lx, ly;
    logic               in_box;
    logic [DIG_W-1:0]   dig;
    logic [GW_LOG2-1:0] gcol;
    logic [GH_LOG2-1:0] grow;

    assign lx     = px_x - 10'(X0);
    assign ly     = px_y - 10'(Y0);
    assign in_box = (int'(px_x) >= X0) && (int'(px_x) < X0 + BOX_W) &&
                    (int'(px_y) >= Y0) && (int'(px_y) < Y0 + BOX_H);
    assign dig    = DIG_W'(lx >> (GW_LOG2 + SCALE_LOG2));
    assign gcol   = GW_LOG2'(lx >> SCALE_LOG2);
    assign grow   = GH_LOG2'(ly >> SCALE_LOG2);

    // Leading-zero blanking walks from the most significant nibble; the last digit always shows.
    logic [NUM_DIGITS-1:0][3:0] eff_code;
    logic                       leading;

    always_comb begin
        eff_code = shad_q;
        leading  = lzb_en;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            if (leading && shad_q[k] == 4'd0) eff_code[k] = BLANK_CODE;
            else                              leading     = 1'b0;
        end
    end

    logic [1:0]         vld_pipe_q;
    logic               s1_show_q;
    logic [3:0]         s1_code_q;
    logic [GW_LOG2-1:0] s1_gcol_q;
    logic [GH_LOG2-1:0] s1_grow_q;
    logic [COLOR_W-1:0] s1_pix_q;
    logic [COLOR_W-1:0] pix_out_q;
    logic               lit;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            s1_show_q  <= 1'b0;
            s1_code_q  <= BLANK_CODE;
            s1_gcol_q  <= '0;
            s1_grow_q  <= '0;
            s1_pix_q   <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], px_valid};
            s1_show_q  <= in_box && phase_on_q;
            s1_code_q  <= eff_code[DIG_W'(NUM_DIGITS - 1) - dig];
            s1_gcol_q  <= gcol;
            s1_grow_q  <= grow;
            s1_pix_q   <= pix_in;
        end
    end

    // ---------------- stage 2: glyph lookup and colour mux ----------------
    glyph_seg_rom #(
        .COL_W (GW_LOG2),
        .ROW_W (GH_LOG2)
    ) u_rom (
        .code_i (s1_code_q),
        .gcol_i (s1_gcol_q),
        .grow_i (s1_grow_q),
        .lit_o  (lit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_out_q <= '0;
        end else if (s1_show_q) begin
            pix_out_q <= lit ? FG_COLOR : BG_COLOR;
        end else begin
            pix_out_q <= s1_pix_q;
        end
    end

    assign pix_out       = pix_out_q;
    assign pix_out_valid = vld_pipe_q[1];

endmodule

// File: tb/tb_digit_overlay.sv
// Bench for digit_overlay: hand vectors for geometry and corner sequences, then random
// pixels and control checked against a frame-level reference model.
module tb_digit_overlay;

    localparam int         X0 = 16;
    localparam int         Y0 = 16;
    localparam int         BOX_W = 64;
    localparam int         BOX_H = 32;
    localparam int         BF = 2;
    localparam logic [5:0] FG = 6'h00;
    localparam logic [5:0] BG = 6'h3F;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_bcd;
    logic        value_valid, frame_start, lzb_en, blink_en, px_valid;
    logic [9:0]  px_x, px_y;
    logic [5:0]  pix_in, pix_out;
    logic        pix_out_valid;

    int nchk = 0;
    int nerr = 0;

    digit_overlay #(.BLINK_FRAMES(BF)) dut (
        .clk           (clk),
        .reset         (reset),
        .value_bcd     (value_bcd),
        .value_valid   (value_valid),
        .frame_start   (frame_start),
        .lzb_en        (lzb_en),
        .blink_en      (blink_en),
        .px_valid      (px_valid),
        .px_x          (px_x),
        .px_y          (px_y),
        .pix_in        (pix_in),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel, let it drain, compare the colour it produced.
    task automatic probe(input string name, input int x, input int y,
                         input logic [5:0] pin, input logic [5:0] exp);
        px_x = 10'(x); px_y = 10'(y); pix_in = pin; px_valid = 1'b1;
        tick();
        px_valid = 1'b0;
        tick();
        chk(name, pix_out, exp);
    endtask

    task automatic commit(input logic [15:0] v);
        value_bcd = v; value_valid = 1'b1;
        tick();
        value_valid = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic string seg_names(input int code);
        case (code)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            15: return "g";
            default: return "";
        endcase
    endfunction

    function automatic bit seg_covers(input byte s, input int c, input int r);
        case (s)
            "a": return (r inside {[1:2]})   && (c inside {[1:6]});
            "b": return (c == 6) && (r inside {[1:7]});
            "c": return (c == 6) && (r inside {[8:14]});
            "d": return (r inside {[13:14]}) && (c inside {[1:6]});
            "e": return (c == 1) && (r inside {[8:14]});
            "f": return (c == 1) && (r inside {[1:7]});
            "g": return (r inside {[7:8]})   && (c inside {[1:6]});
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] model_px(input int x, input int y, input logic [5:0] pin,
                                            input logic [15:0] val, input bit lzb, input bit on);
        int    lx, ly, d, c, r;
        int    dg[4];
        string s;
        bit    lit;
        lx = x - X0;
        ly = y - Y0;
        if (lx < 0 || ly < 0 || lx >= BOX_W || ly >= BOX_H || !on) return pin;
        d = lx / 16;
        c = (lx / 2) % 8;
        r = ly / 2;
        for (int i = 0; i < 4; i++) dg[i] = int'((val >> (4 * (3 - i))) & 16'hF);
        if (lzb) for (int i = 0; i < 3 && dg[i] == 0; i++) dg[i] = 10;
        s   = seg_names(dg[d]);
        lit = 1'b0;
        for (int i = 0; i < s.len(); i++) if (seg_covers(s[i], c, r)) lit = 1'b1;
        return lit ? FG : BG;
    endfunction

    typedef struct {
        string      name;
        int         x;
        int         y;
        logic [5:0] pin;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        logic       v;
        logic [5:0] p;
    } exp_t;

    vec_t tbl[16];
    exp_t q[$];

    initial begin
        logic [15:0] m_pend, m_shad;
        int          m_cnt;
        bit          m_on;
        bit          on_pat[6];
        exp_t        e;

        reset = 1'b1; value_bcd = '0; value_valid = 1'b0; frame_start = 1'b0;
        lzb_en = 1'b0; blink_en = 1'b0; px_valid = 1'b0;
        px_x = '0; px_y = '0; pix_in = '0;
        repeat (3) tick();
        chk("reset_pix", pix_out, 6'h00);
        chk("reset_valid", pix_out_valid, 1'b0);
        reset = 1'b0;
        tick();

        probe("blank_at_start", X0 + 12, Y0 + 2, 6'h11, BG);

        // latency: valid appears exactly two edges after the pixel
        px_x = 10'(X0 + 12); px_y = 10'(Y0 + 2); pix_in = 6'h11; px_valid = 1'b1;
        tick();
        px_valid = 1'b0;
        chk("lat_cycle1_valid", pix_out_valid, 1'b0);
        tick();
        chk("lat_cycle2_valid", pix_out_valid, 1'b1);
        tick();
        chk("lat_cycle3_valid", pix_out_valid, 1'b0);

        // geometry table for value 1234
        commit(16'h1234);
        tbl[0]  = '{"left_out",     X0 - 1,  Y0,      6'h05, 6'h05};
        tbl[1]  = '{"right_out",    X0 + 64, Y0,      6'h07, 6'h07};
        tbl[2]  = '{"corner",       X0,      Y0,      6'h09, BG};
        tbl[3]  = '{"d0_interior",  X0 + 2,  Y0 + 2,  6'h11, BG};
        tbl[4]  = '{"d0_b_top",     X0 + 12, Y0 + 2,  6'h11, FG};
        tbl[5]  = '{"d0_c_bottom",  X0 + 13, Y0 + 29, 6'h11, FG};
        tbl[6]  = '{"d0_row15",     X0 + 12, Y0 + 30, 6'h11, BG};
        tbl[7]  = '{"d1_a",         X0 + 18, Y0 + 2,  6'h11, FG};
        tbl[8]  = '{"d1_e",         X0 + 18, Y0 + 20, 6'h11, FG};
        tbl[9]  = '{"d1_no_f",      X0 + 18, Y0 + 6,  6'h11, BG};
        tbl[10] = '{"d2_g",         X0 + 34, Y0 + 14, 6'h11, FG};
        tbl[11] = '{"d3_f",         X0 + 50, Y0 + 2,  6'h11, FG};
        tbl[12] = '{"d3_no_a",      X0 + 56, Y0 + 2,  6'h11, BG};
        tbl[13] = '{"bottom_out",   X0,      Y0 + 32, 6'h2A, 6'h2A};
        tbl[14] = '{"last_px",      X0 + 63, Y0 + 31, 6'h11, BG};
        tbl[15] = '{"top_out",      X0 + 2,  Y0 - 1,  6'h15, 6'h15};
        for (int i = 0; i < 16; i++) probe(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].pin, tbl[i].exp);

        // mid-frame write does not tear
        value_bcd = 16'h0007; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        probe("mid_frame_hold", X0 + 12, Y0 + 2, 6'h11, FG);
        lzb_en = 1'b1;
        pulse_fs();
        probe("lzb_d0_blank", X0 + 2,  Y0 + 2, 6'h11, BG);
        probe("lzb_d2_blank", X0 + 34, Y0 + 2, 6'h11, BG);
        probe("lzb_d3_a",     X0 + 50, Y0 + 2, 6'h11, FG);
        probe("lzb_d3_no_f",  X0 + 50, Y0 + 6, 6'h11, BG);
        lzb_en = 1'b0;
        probe("nolzb_d0_zero", X0 + 2, Y0 + 2, 6'h11, FG);

        // last write wins on the committing frame_start; minus and blank codes
        value_bcd = 16'hF005; value_valid = 1'b1;
        tick();
        value_bcd = 16'hF0A5; frame_start = 1'b1;
        tick();
        value_valid = 1'b0; frame_start = 1'b0;
        lzb_en = 1'b1;
        probe("minus_g",        X0 + 4,  Y0 + 14, 6'h11, FG);
        probe("minus_no_a",     X0 + 4,  Y0 + 2,  6'h11, BG);
        probe("code_a_blank",   X0 + 34, Y0 + 14, 6'h11, BG);
        probe("zero_after_min", X0 + 18, Y0 + 2,  6'h11, FG);
        probe("d3_five_a",      X0 + 50, Y0 + 2,  6'h11, FG);

        // blink: two frames on, two off, two on
        on_pat = '{1, 1, 0, 0, 1, 1};
        blink_en = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            probe($sformatf("blink_frame%0d", k), X0 + 4, Y0 + 14, 6'h2A, on_pat[k] ? FG : 6'h2A);
            pulse_fs();
        end
        probe("blink_off_again", X0 + 4, Y0 + 14, 6'h2A, 6'h2A);
        blink_en = 1'b0;
        tick();
        probe("blink_drop", X0 + 4, Y0 + 14, 6'h2A, FG);

        // reset in the middle of a scan
        px_x = 10'(X0 + 12); px_y = 10'(Y0 + 2); pix_in = 6'h11; px_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_valid0", pix_out_valid, 1'b0);
        chk("rst_mid_pix0", pix_out, 6'h00);
        reset = 1'b0;
        tick();
        chk("rst_mid_valid1", pix_out_valid, 1'b0);
        tick();
        chk("rst_mid_valid2", pix_out_valid, 1'b1);
        chk("rst_mid_blank", pix_out, BG);
        px_valid = 1'b0;
        pulse_fs();
        probe("rst_fs_only_blank", X0 + 12, Y0 + 2, 6'h11, BG);
        commit(16'h1234);
        probe("rst_recommit", X0 + 12, Y0 + 2, 6'h11, FG);

        // randomized traffic against the model
        reset = 1'b1;
        tick();
        reset = 1'b0; lzb_en = 1'b0; blink_en = 1'b0;
        m_pend = 16'hAAAA; m_shad = 16'hAAAA; m_cnt = 0; m_on = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            px_valid    = ($urandom % 4) != 0;
            px_x        = 10'($urandom_range(0, 100));
            px_y        = 10'($urandom_range(0, 60));
            pix_in      = 6'($urandom);
            frame_start = ($urandom % 25) == 0;
            value_valid = ($urandom % 8) == 0;
            for (int i = 0; i < 4; i++)
                value_bcd[4*i +: 4] = ($urandom % 2) ? 4'($urandom) : 4'd0;
            if ($urandom % 50 == 0)  lzb_en   = !lzb_en;
            if ($urandom % 300 == 0) blink_en = !blink_en;

            e.v = px_valid;
            e.p = model_px(int'(px_x), int'(px_y), pix_in, m_shad, lzb_en, m_on);
            q.push_back(e);

            if (value_valid) m_pend = value_bcd;
            if (frame_start) m_shad = m_pend;
            if (!blink_en) begin
                m_cnt = 0;
                m_on  = 1'b1;
            end else if (frame_start) begin
                m_cnt++;
                if (m_cnt == BF) begin
                    m_cnt = 0;
                    m_on  = !m_on;
                end
            end

            tick();
            if (q.size() == 2) begin
                e = q.pop_front();
                chk("rnd_valid", pix_out_valid, e.v);
                if (e.v) chk("rnd_pix", pix_out, e.p);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
